// File: rtl/ps2_scan_receiver.sv
// ps2_scan_receiver
//   Receives 11-bit PS/2 keyboard frames on the raw pins and validates each
//   frame. Every accepted scan code is published with a one-cycle strobe and
//   is shifted into a 32-bit history of the last four codes (newest in [7:0]).
//   Partial frames are abandoned after TIMEOUT_CYCLES idle system clocks.
//
//   Optional macro PS2_PARITY_CHECK_EN: when defined, frames with bad odd
//   parity are rejected; otherwise the parity bit is sampled but ignored.
//
// Parameters:
//   TIMEOUT_CYCLES  clk cycles without a PS/2 falling edge before abandoning
//   TO_W            timeout counter width (must hold TIMEOUT_CYCLES-1)
// Ports:
//   clk         system clock, rising edge
//   reset       asynchronous active-high reset
//   ps2_clk     raw PS/2 clock pin (async, idles high)
//   ps2_data    raw PS/2 data pin (async, idles high)
//   code        last accepted scan code
//   code_valid  one-cycle pulse when code/x update
//   x           history {b3,b2,b1,b0}, b0 newest
//   frame_err   one-cycle pulse on a rejected or abandoned frame
module ps2_scan_receiver #(
  parameter int unsigned TIMEOUT_CYCLES = 50000,
  parameter int unsigned TO_W           = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  output logic [7:0]  code,
  output logic        code_valid,
  output logic [31:0] x,
  output logic        frame_err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  state_t          state_q, state_d;
  logic            clk_s1_q, clk_s2_q, clk_prev_q;
  logic            data_s1_q, data_s2_q;
  logic [2:0]      bit_cnt_q, bit_cnt_d;
  logic [7:0]      shift_q, shift_d;
  logic            par_q, par_d;
  logic [TO_W-1:0] to_cnt_q, to_cnt_d, to_inc;
  logic [7:0]      code_q, code_d;
  logic [31:0]     x_q, x_d;
  logic            code_valid_q, code_valid_d;
  logic            frame_err_q, frame_err_d;
  logic            fe;
  logic            parity_ok;

  // Two-flop synchronisers plus one history flop for edge detection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clk_s1_q   <= 1'b1;
      clk_s2_q   <= 1'b1;
      clk_prev_q <= 1'b1;
      data_s1_q  <= 1'b1;
      data_s2_q  <= 1'b1;
    end else begin
      clk_s1_q   <= ps2_clk;
      clk_s2_q   <= clk_s1_q;
      clk_prev_q <= clk_s2_q;
      data_s1_q  <= ps2_data;
      data_s2_q  <= data_s1_q;
    end
  end

  assign fe = clk_prev_q & ~clk_s2_q;

`ifdef PS2_PARITY_CHECK_EN
  assign parity_ok = ^{shift_q, par_q};
`else
  assign parity_ok = 1'b1;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      par_q        <= 1'b0;
      to_cnt_q     <= '0;
      code_q       <= '0;
      x_q          <= '0;
      code_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      par_q        <= par_d;
      to_cnt_q     <= to_cnt_d;
      code_q       <= code_d;
      x_q          <= x_d;
      code_valid_q <= code_valid_d;
      frame_err_q  <= frame_err_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    par_d        = par_q;
    to_cnt_d     = to_cnt_q;
    code_d       = code_q;
    x_d          = x_q;
    code_valid_d = 1'b0;
    frame_err_d  = 1'b0;
    to_inc       = to_cnt_q + 1'b1;

    if (state_q == S_IDLE) begin
      to_cnt_d = '0;
      if (fe && !data_s2_q) begin
        state_d   = S_DATA;
        bit_cnt_d = '0;
      end
    end else if (fe) begin
      // A falling edge always wins over a coincident timeout.
      to_cnt_d = '0;
      case (state_q)
        S_DATA: begin
          shift_d[bit_cnt_q] = data_s2_q;
          bit_cnt_d          = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            state_d = S_PARITY;
          end
        end
        S_PARITY: begin
          par_d   = data_s2_q;
          state_d = S_STOP;
        end
        default: begin
          if (data_s2_q && parity_ok) begin
            code_d       = shift_q;
            x_d          = {x_q[23:0], shift_q};
            code_valid_d = 1'b1;
          end else begin
            frame_err_d = 1'b1;
          end
          state_d = S_IDLE;
        end
      endcase
    end else if (to_inc == TO_LAST) begin
      // Abandon on the cycle the counter would reach TIMEOUT_CYCLES-1.
      state_d     = S_IDLE;
      to_cnt_d    = '0;
      frame_err_d = 1'b1;
    end else begin
      to_cnt_d = to_inc;
    end
  end

  assign code       = code_q;
  assign code_valid = code_valid_q;
  assign x          = x_q;
  assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_ps2_scan_receiver.sv
// Directed self-checking bench for ps2_scan_receiver (TIMEOUT_CYCLES=200,
// PS/2 bit period 40 clk). Expectations for the bad-parity frame follow
// whether PS2_PARITY_CHECK_EN is defined for the build.
module tb_ps2_scan_receiver;

  logic        clk;
  logic        reset;
  logic        ps2_clk;
  logic        ps2_data;
  logic [7:0]  code;
  logic        code_valid;
  logic [31:0] x;
  logic        frame_err;

  int unsigned n_checks;
  int unsigned n_fail;
  int unsigned cv_cnt, fe_cnt, both_cnt;
  int unsigned cv_run, fe_run, cv_max, fe_max;

  ps2_scan_receiver #(
    .TIMEOUT_CYCLES(200),
    .TO_W          (8)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .code      (code),
    .code_valid(code_valid),
    .x         (x),
    .frame_err (frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse monitor: counts strobes, their lengths and any overlap.
  always @(negedge clk) begin
    if (code_valid) begin
      cv_cnt <= cv_cnt + 1;
      cv_run <= cv_run + 1;
      if (cv_run + 1 > cv_max) cv_max <= cv_run + 1;
    end else begin
      cv_run <= 0;
    end
    if (frame_err) begin
      fe_cnt <= fe_cnt + 1;
      fe_run <= fe_run + 1;
      if (fe_run + 1 > fe_max) fe_max <= fe_run + 1;
    end else begin
      fe_run <= 0;
    end
    if (code_valid && frame_err) both_cnt <= both_cnt + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic wait_clk(input int unsigned n);
    repeat (n) @(negedge clk);
  endtask

  // Sends the first nbits of {stop, p, b, start=0}, LSB first.
  task automatic send_frame(input logic [7:0] b, input logic p, input logic stop,
                            input int unsigned nbits);
    logic [10:0] f;
    f = {stop, p, b, 1'b0};
    for (int unsigned i = 0; i < nbits; i++) begin
      ps2_data = f[i];
      wait_clk(20);
      ps2_clk = 1'b0;
      wait_clk(20);
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
    wait_clk(20);
  endtask

  logic [31:0] exp_x;
  int unsigned k;
  int unsigned cv_snap, fe_snap;

  initial begin
    n_checks = 0; n_fail = 0;
    cv_cnt = 0; fe_cnt = 0; both_cnt = 0;
    cv_run = 0; fe_run = 0; cv_max = 0; fe_max = 0;
    reset = 1'b1; ps2_clk = 1'b1; ps2_data = 1'b1;
    wait_clk(3);
    check_eq("rst_code", {24'h0, code}, 32'h0);
    check_eq("rst_x", x, 32'h0);
    check_eq("rst_cv", {31'h0, code_valid}, 32'h0);
    check_eq("rst_fe", {31'h0, frame_err}, 32'h0);
    reset = 1'b0;
    wait_clk(5);

    // First frame 0x45
    check_eq("pre45_x", x, 32'h0);
    send_frame(8'h45, 1'b0, 1'b1, 11);
    check_eq("f45_code", {24'h0, code}, 32'h45);
    check_eq("f45_x", x, 32'h0000_0045);
    check_eq("f45_cv", cv_cnt, 1);
    check_eq("f45_fe", fe_cnt, 0);

    // Three more codes, including break 0xF0
    send_frame(8'h16, 1'b0, 1'b1, 11);
    send_frame(8'hF0, 1'b1, 1'b1, 11);
    send_frame(8'h16, 1'b0, 1'b1, 11);
    exp_x = 32'h4516_F016;
    check_eq("seq_x", x, exp_x);
    check_eq("seq_cv", cv_cnt, 4);
    check_eq("seq_fe", fe_cnt, 0);

    // 0x1E with wrong parity bit
    send_frame(8'h1E, 1'b0, 1'b1, 11);
`ifdef PS2_PARITY_CHECK_EN
    check_eq("par_fe", fe_cnt, 1);
    check_eq("par_cv", cv_cnt, 4);
    check_eq("par_x", x, exp_x);
`else
    exp_x = {exp_x[23:0], 8'h1E};
    check_eq("par_fe", fe_cnt, 0);
    check_eq("par_cv", cv_cnt, 5);
    check_eq("par_x", x, exp_x);
`endif

    // Bad stop bit, then a good 0x26
    cv_snap = cv_cnt; fe_snap = fe_cnt;
    send_frame(8'h26, 1'b0, 1'b0, 11);
    check_eq("stop_fe", fe_cnt, fe_snap + 1);
    check_eq("stop_cv", cv_cnt, cv_snap);
    check_eq("stop_x", x, exp_x);
    send_frame(8'h26, 1'b0, 1'b1, 11);
    exp_x = {exp_x[23:0], 8'h26};
    check_eq("f26_code", {24'h0, code}, 32'h26);

    // Timeout: start, d0, d1, then d2 and silence
    cv_snap = cv_cnt; fe_snap = fe_cnt;
    send_frame(8'h25, 1'b0, 1'b1, 3);
    ps2_data = 1'b1;            // d2 of 0x25
    wait_clk(20);
    ps2_clk = 1'b0;
    k = 0;
    while (k < 300 && !frame_err) begin
      @(negedge clk);
      k++;
      if (k == 20) ps2_clk = 1'b1;
    end
    // 2 synchroniser edges + fe-consuming edge, then 199 more edges
    check_eq("to_delay", k, 202);
    wait_clk(50);
    check_eq("to_fe", fe_cnt, fe_snap + 1);
    check_eq("to_cv", cv_cnt, cv_snap);
    send_frame(8'h25, 1'b0, 1'b1, 11);
    exp_x = {exp_x[23:0], 8'h25};
    check_eq("f25_code", {24'h0, code}, 32'h25);
    check_eq("f25_x", x, exp_x);

    // Reset in the middle of a 0x3D frame (after d4)
    send_frame(8'h3D, 1'b0, 1'b1, 6);
    cv_snap = cv_cnt; fe_snap = fe_cnt;
    reset = 1'b1;
    wait_clk(2);
    reset = 1'b0;
    wait_clk(2);
    check_eq("mrst_code", {24'h0, code}, 32'h0);
    check_eq("mrst_x", x, 32'h0);
    wait_clk(250);
    check_eq("mrst_cv", cv_cnt, cv_snap);
    check_eq("mrst_fe", fe_cnt, fe_snap);
    send_frame(8'h3D, 1'b0, 1'b1, 11);
    check_eq("f3d_x", x, 32'h0000_003D);
    check_eq("f3d_code", {24'h0, code}, 32'h3D);

    check_eq("cv_width", cv_max, 1);
    check_eq("fe_width", fe_max, 1);
    check_eq("no_overlap", both_cnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ps2_scan_receiver.md
Name: ps2_scan_receiver

Overview:
- Upstream stage of the 7-segment scan-code display.
- Receives PS/2 keyboard frames on the raw ps2_clk/ps2_data pins and validates each 11-bit frame.
- Publishes each accepted scan-code byte with a one-cycle strobe.
- Maintains a 32-bit history of the last four accepted bytes (newest in [7:0]) that drives the display's 32-bit input directly.

Parameters:
- TIMEOUT_CYCLES, 50000, system-clock cycles without a PS/2 falling edge before a partial frame is abandoned (1 ms at 50 MHz).
- TO_W, 16, width of the timeout counter; must hold TIMEOUT_CYCLES-1.

Ports:
- clk  input  1  system clock; all state on rising edge.
- reset  input  1  asynchronous, active-high reset.
- ps2_clk  input  1  raw PS/2 clock pin, asynchronous, idles high.
- ps2_data  input  1  raw PS/2 data pin, asynchronous, idles high.
- code  output  8  last accepted scan code.
- code_valid  output  1  one-cycle pulse when code/x update.
- x  output  32  history {b3,b2,b1,b0}; b0 = newest byte.
- frame_err  output  1  one-cycle pulse on a rejected or abandoned frame.

Behaviour:
- Reset (async, active-high):
  - state=IDLE; code=0, x=0, code_valid=0, frame_err=0.
  - Sync flops and edge-history flop = 1; bit counter and timeout counter = 0.
  - A reset mid-frame discards the partial frame. No pulse.
- Synchronisation: two-flop synchroniser on each of ps2_clk and ps2_data. Falling edge fe = (prev synced clk == 1) && (synced clk == 0). Data is sampled from the synced ps2_data in the fe cycle.
- Frame: start(0), d0..d7 LSB first, odd parity, stop(1).
- FSM states:
  - IDLE: on fe with data==0 -> DATA, bit_cnt=0. On fe with data==1 -> stay (spurious edge ignored).
  - DATA: on fe shift data in at bit position bit_cnt and increment bit_cnt. After the 8th bit (bit_cnt==7) -> PARITY.
  - PARITY: on fe latch p -> STOP.
  - STOP: on fe, evaluate the frame. Accept if stop==1 and the parity check passes. On accept: code<=byte, x<={x[23:0],byte}, code_valid=1. Otherwise frame_err=1, and code/x are unchanged. Always -> IDLE.
- Latency: if the stop-bit fe occurs in cycle N, then code, x and the pulse are visible in cycle N+1. The pulse lasts exactly one cycle.
- Timeout:
  - Counter clears on every fe and while in IDLE; it increments each cycle in DATA/PARITY/STOP.
  - When it reaches TIMEOUT_CYCLES-1: -> IDLE, frame_err pulse, counter cleared, nothing published.
  - If fe and timeout fall in the same cycle, fe wins and the counter is cleared.
- code_valid and frame_err are never asserted in the same cycle.
- x shifts only on accept. Byte F0 (break) is stored like any other code; no interpretation is applied.
- No host-to-device transmit. Pins are input-only.

Optional Feature:
- Macro PS2_PARITY_CHECK_EN.
  - Defined: accept requires XOR(d0..d7,p)==1 (odd parity). A frame with bad parity raises frame_err and is not stored.
  - Undefined: the parity bit is sampled but ignored, so acceptance depends on the stop bit only. frame_err is then raised only for a bad stop bit or a timeout.

Test Plan:
- Bench setup: TIMEOUT_CYCLES=200, PS/2 bit period 40 clk, PS2_PARITY_CHECK_EN defined unless stated.
- After reset, send frame 0x45 (p=0) -> x=0x00000000 before the frame; then code=0x45, one-cycle code_valid, x=0x00000045, frame_err never asserted.
- Send 0x16 (p=0), 0xF0 (p=1), 0x16 (p=0) after 0x45 -> three code_valid pulses; x=0x4516F016 at the end.
- Send 0x1E with p=0 (bad parity) -> frame_err pulse, no code_valid, x unchanged. With the macro undefined, the same frame is accepted and x[7:0]=0x1E.
- Send 0x26 with stop=0 -> frame_err pulse, x unchanged. A following good 0x26 frame is accepted: code=0x26.
- Send start + 3 data bits, then hold ps2_clk high for 250 cycles -> frame_err pulse exactly 199 cycles after the last fe. A following good 0x25 frame is accepted.
- Assert reset for 2 cycles mid-frame (after bit d4) -> outputs 0, no pulses. A following good 0x3D frame gives x=0x0000003D.
